// File: rtl/noc_pkg.sv
// Shared NoC definitions: default packet width, packet field positions and
// the packet type used by router-port blocks.
package noc_pkg;

   localparam int unsigned WIDTH_PACKET_DEF = 14;

   // Destination field occupies the upper packet bits. Each tree level
   // decodes one bit of it; ROUTE_BIT_DEF is the bit used at this level.
   localparam int unsigned DEST_MSB      = 13;
   localparam int unsigned DEST_LSB      = 8;
   localparam int unsigned ROUTE_BIT_DEF = 10;

   typedef logic [WIDTH_PACKET_DEF-1:0] packet_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head output.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears storage too)
//   push_i, wdata_i   write request and data (ignored when full)
//   pop_i             read request (ignored when empty)
//   head_o            entry at the read pointer
//   full_o, empty_o   status flags
//   occupancy_o       current number of stored entries
module sync_fifo #(
   parameter int unsigned WIDTH = 14,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned OccW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0]  occ_q, occ_d;
   logic             push_ok, pop_ok;

   assign full_o      = (occ_q == OccW'(DEPTH));
   assign empty_o     = (occ_q == '0);
   assign occupancy_o = occ_q;
   assign head_o      = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // DEPTH is a power of two, so pointer increment wraps naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   occ_d = occ_q + OccW'(1);
         2'b01:   occ_d = occ_q - OccW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/input_ctrl.sv
// Ingress stage of one NoC tree-router port: buffers link packets in a FIFO,
// decodes the routing bit of the head packet and offers it to exactly one of
// two output controllers with a valid/ready handshake. Counts forwarded
// packets per output.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid, in_data, in_ready   upstream link handshake
//   out0_valid/data/ready         downstream output 0 (route bit = 0)
//   out1_valid/data/ready         downstream output 1 (route bit = 1)
//   fwd_cnt0, fwd_cnt1            wrapping forwarded-packet counters
//   occupancy                     current FIFO fill
module input_ctrl
   import noc_pkg::*;
#(
   parameter int unsigned WIDTH_packet = WIDTH_PACKET_DEF,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned ROUTE_BIT    = ROUTE_BIT_DEF,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [WIDTH_packet-1:0]   in_data,
   output logic                      in_ready,
   output logic                      out0_valid,
   output logic [WIDTH_packet-1:0]   out0_data,
   input  logic                      out0_ready,
   output logic                      out1_valid,
   output logic [WIDTH_packet-1:0]   out1_data,
   input  logic                      out1_ready,
   output logic [CNT_W-1:0]          fwd_cnt0,
   output logic [CNT_W-1:0]          fwd_cnt1,
   output logic [$clog2(DEPTH):0]    occupancy
);

   logic [WIDTH_packet-1:0] head;
   logic                    full, empty;
   logic                    sel;
   logic                    push, pop0, pop1;
   logic [CNT_W-1:0]        cnt0_q, cnt0_d;
   logic [CNT_W-1:0]        cnt1_q, cnt1_d;

   // in_ready is gated by rst_n so nothing is accepted while reset is held.
   assign in_ready = rst_n & ~full;
   assign push     = in_valid & in_ready;

   assign sel        = head[ROUTE_BIT];
   assign out0_valid = ~empty & ~sel;
   assign out1_valid = ~empty & sel;
   assign out0_data  = head;
   assign out1_data  = head;

   // Only the selected output's ready can pop; the other ready is ignored.
   assign pop0 = out0_valid & out0_ready;
   assign pop1 = out1_valid & out1_ready;

   sync_fifo #(
      .WIDTH (WIDTH_packet),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .wdata_i     (in_data),
      .pop_i       (pop0 | pop1),
      .head_o      (head),
      .full_o      (full),
      .empty_o     (empty),
      .occupancy_o (occupancy)
   );

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (pop0) cnt0_d = cnt0_q + CNT_W'(1);
      if (pop1) cnt1_d = cnt1_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign fwd_cnt0 = cnt0_q;
   assign fwd_cnt1 = cnt1_q;

endmodule

// File: doc/input_ctrl.md
Name: input_ctrl

Overview:
- Clocked ingress stage of one NoC tree router port. It sits directly upstream of the per-output 2:1 merge/arbitration stage.
- Accepts 14-bit packets from a link, buffers them in a small FIFO, and decodes one routing bit of each packet's destination field.
- Steers the head packet to exactly one of two downstream output-control inputs with a valid/ready handshake.
- One instance per router input port. Its out0/out1 feed the "in1"/"in2" inputs of two different output controllers.

Parameters:
- WIDTH_packet, 14, packet width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ROUTE_BIT, 10, packet bit index that selects the output (0 -> out0, 1 -> out1); must be < WIDTH_packet.
- CNT_W, 16, width of per-output forwarded-packet counters.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream offers packet.
- in_data, input, WIDTH_packet, upstream packet.
- in_ready, output, 1, FIFO can accept this cycle.
- out0_valid, output, 1, head packet offered to output 0.
- out0_data, output, WIDTH_packet, packet to output 0.
- out0_ready, input, 1, output 0 consumer accepts.
- out1_valid, output, 1, head packet offered to output 1.
- out1_data, output, WIDTH_packet, packet to output 1.
- out1_ready, input, 1, output 1 consumer accepts.
- fwd_cnt0, output, CNT_W, packets forwarded on out0.
- fwd_cnt1, output, CNT_W, packets forwarded on out1.
- occupancy, output, $clog2(DEPTH)+1, current FIFO fill.

Behaviour:
- Clock and reset: single clock, clk; reset is asynchronous, active-low on rst_n.
- Reset (rst_n low, takes effect immediately without waiting for clk):
  - wr_ptr, rd_ptr, occupancy, fwd_cnt0 and fwd_cnt1 are cleared to 0.
  - out0_valid and out1_valid go to 0; in_ready goes to 0 while rst_n is low.
  - out*_data are don't-care but are driven from the cleared head entry, so they read 0.
- Reset asserted mid-transfer discards all buffered packets; no partial handshake completes.
- Push: in_ready = rst_n & (occupancy != DEPTH). A write occurs on a rising clk edge when in_valid & in_ready. There is no bypass, so a full FIFO never accepts a push in the same cycle as a pop.
- Head decode is combinational from FIFO entry rd_ptr:
  - sel = head[ROUTE_BIT].
  - out0_valid = nonempty & ~sel; out1_valid = nonempty & sel.
  - Both out*_data carry the head packet; only the selected valid is asserted.
- Exactly one output valid at most, ever. Both valids are 0 when empty.
- Pop: occurs on the edge where the selected valid and its ready are both 1. The ready of the unselected output is ignored.
- Stability: once a valid is asserted, it and its data are held until accepted. The other output's ready has no effect. Head-of-line blocking is intentional.
- Latency: a packet accepted at edge t is visible on its output from edge t (registered into the FIFO) when the FIFO was empty. The earliest pop is edge t+1. Throughput is one packet per cycle when the consumer is always ready.
- Simultaneous push and pop (not full, not empty): both pointers advance and occupancy is unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. occupancy is tracked separately to distinguish full from empty.
- Counters: fwd_cnt0/fwd_cnt1 increment by 1 on each pop to the corresponding output. They wrap from 2^CNT_W-1 to 0 and do not saturate.
- in_data is not sampled when in_ready is 0. X on in_data with in_valid=0 must not propagate.

Decomposition:
- Shared package noc_pkg:
  - WIDTH_packet default and the packet field positions (ROUTE_BIT default, dest field MSB/LSB).
  - typedef logic [WIDTH_packet-1:0] packet_t.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH). It provides push/pop, a head output, full/empty and occupancy.
- input_ctrl adds the route decode, the handshake steering and the counters.

Test Plan:
- Reset and idle: hold rst_n low, then release; no input -> in_ready=1 after release, both valids 0, occupancy 0, counters 0.
- Routing: push 14'h0000, then 14'h0400 (bit 10 set), with both readies high:
  - first packet appears on out0 only, second on out1 only;
  - fwd_cnt0=1, fwd_cnt1=1, one packet per cycle.
- Backpressure and full:
  - hold out0_ready=0; push 5 packets with bit10=0 -> 4 accepted, in_ready=0 on the 5th, occupancy=4, out0_data stable;
  - then raise out0_ready -> drained in FIFO order across 4 cycles, pointer wrap exercised.
- Head-of-line: head routes to out1 with out1_ready=0 and out0_ready=1 -> nothing pops, out0_valid=0. Raising out1_ready pops exactly one packet.
- Simultaneous push and pop at occupancy 2: in_valid=1 and the selected ready=1 for 10 cycles -> occupancy stays 2, order preserved.
- Async reset mid-stream: with 3 packets buffered, drop rst_n between clock edges -> valids and occupancy go to 0 before the next edge; after release the old packets never appear.
